// File: rtl/timed_action_if.sv
// timed_action_if: button, collision and frame-output signals of one player's action controller
interface timed_action_if #(
  parameter int HEALTH_WIDTH = 3,
  parameter int SCORE_WIDTH = 4
);
  logic ir_in_valid;
  logic block_in;
  logic lunge_in;
  logic tick_in;
  logic hit_in;
  logic parry_in;
  logic opponent_scored_in;
  logic [1:0] saber_state_out;
  logic [HEALTH_WIDTH-1:0] health_out;
  logic [SCORE_WIDTH-1:0] score_out;
  logic player_scored_out;
  logic game_over_out;
  logic data_out_valid;
  modport master (
    output ir_in_valid, block_in, lunge_in, tick_in, hit_in, parry_in, opponent_scored_in,
    input saber_state_out, health_out, score_out, player_scored_out, game_over_out, data_out_valid
  );
  modport slave (
    input ir_in_valid, block_in, lunge_in, tick_in, hit_in, parry_in, opponent_scored_in,
    output saber_state_out, health_out, score_out, player_scored_out, game_over_out, data_out_valid
  );
endinterface

// File: rtl/timed_action_fsm.sv
// timed_action_fsm: per-player fencing action controller evaluated once per frame tick
module timed_action_fsm #(
  parameter int MAX_HEALTH = 5,
  parameter int HEALTH_WIDTH = 3,
  parameter int SCORE_WIDTH = 4,
  parameter int LUNGE_FRAMES = 2,
  parameter int ATTACK_FRAMES = 8,
  parameter int BLOCK_FRAMES = 30,
  parameter int RECOVER_FRAMES = 4
) (
  input logic clk_pixel_in,
  input logic rst_in,
  timed_action_if.slave bus
);
  localparam int MAX_LA = LUNGE_FRAMES > ATTACK_FRAMES ? LUNGE_FRAMES : ATTACK_FRAMES;
  localparam int MAX_BR = BLOCK_FRAMES > RECOVER_FRAMES ? BLOCK_FRAMES : RECOVER_FRAMES;
  localparam int MAX_F = MAX_LA > MAX_BR ? MAX_LA : MAX_BR;
  localparam int TW = $clog2(MAX_F) + 1;
  typedef enum logic [2:0] {REST, LUNGE, BLOCK, ATTACK, SCORE, RECOVER, DEAD} state_t;
  state_t state, state_d;
  logic [TW-1:0] timer, timer_d;
  logic [HEALTH_WIDTH-1:0] health, health_d;
  logic [SCORE_WIDTH-1:0] score, score_d;
  logic [1:0] saber_d;
  logic block_q, lunge_q, dmg, inc;
  always_comb begin
    state_d = state;
    dmg = 1'b0;
    inc = 1'b0;
    if (bus.tick_in)
      case (state)
        REST:
          if (bus.opponent_scored_in) dmg = 1'b1;
          else if (block_q) state_d = BLOCK;
          else if (lunge_q) state_d = LUNGE;
        BLOCK:
          if (bus.parry_in) begin
            inc = 1'b1;
            state_d = RECOVER;
          end
          else if (!block_q) state_d = REST;
          else if (timer == TW'(BLOCK_FRAMES - 1)) state_d = RECOVER;
        LUNGE:
          if (bus.opponent_scored_in) dmg = 1'b1;
          else if (timer == TW'(LUNGE_FRAMES - 1)) state_d = ATTACK;
        ATTACK:
          if (bus.hit_in && bus.opponent_scored_in) begin
            inc = 1'b1;
            dmg = 1'b1;
          end
          else if (bus.hit_in) state_d = SCORE;
          else if (bus.opponent_scored_in) dmg = 1'b1;
          else if (!lunge_q || timer == TW'(ATTACK_FRAMES - 1)) state_d = RECOVER;
        SCORE: begin
          inc = 1'b1;
          state_d = RECOVER;
        end
        RECOVER:
          if (timer == TW'(RECOVER_FRAMES - 1)) state_d = REST;
        default: ;
      endcase
    // a touch that takes the last point of health ends the game instead of recovering
    if (dmg) state_d = health == HEALTH_WIDTH'(1) ? DEAD : RECOVER;
    health_d = health - HEALTH_WIDTH'(dmg);
    score_d = (inc && score != '1) ? score + SCORE_WIDTH'(1) : score;
    timer_d = !bus.tick_in ? timer : (state_d != state ? '0 : timer + TW'(1));
    saber_d = state_d == LUNGE ? 2'b01 : state_d == BLOCK ? 2'b10 : state_d == ATTACK ? 2'b11 : 2'b00;
  end
  always_ff @(posedge clk_pixel_in) begin
    if (rst_in) begin
      state <= REST;
      timer <= '0;
      health <= HEALTH_WIDTH'(MAX_HEALTH);
      score <= '0;
      block_q <= 1'b0;
      lunge_q <= 1'b0;
      bus.saber_state_out <= 2'b00;
      bus.game_over_out <= 1'b0;
      bus.data_out_valid <= 1'b0;
      bus.player_scored_out <= 1'b0;
    end else begin
      state <= state_d;
      timer <= timer_d;
      health <= health_d;
      score <= score_d;
      bus.saber_state_out <= saber_d;
      bus.game_over_out <= state_d == DEAD;
      bus.data_out_valid <= bus.tick_in;
      bus.player_scored_out <= inc;
      if (bus.ir_in_valid) begin
        block_q <= bus.block_in;
        lunge_q <= bus.lunge_in & ~bus.block_in;
      end
    end
  end
  assign bus.health_out = health;
  assign bus.score_out = score;
endmodule

// File: tb/tb_timed_action_fsm.sv
// tb_timed_action_fsm: directed and random frames on two parameter sets, checked every cycle against a countdown model
module tb_timed_action_fsm;
  localparam int S_REST = 0, S_LUNGE = 1, S_BLOCK = 2, S_ATTACK = 3, S_SCORE = 4, S_RECOVER = 5, S_DEAD = 6;
  typedef struct {int st; int left; int health; int score; bit bq; bit lq;} m_t;
  typedef struct {int lf; int af; int bf; int rf; int mh; int smax;} p_t;
  logic clk = 0, rst = 1, irv = 0, blk = 0, lng = 0, tick = 0, hit = 0, parry = 0, opp = 0;
  int total = 0, bad = 0, pulses1 = 0, ps2 = 0;
  bit armed = 0, e_dv = 0, e_ps1 = 0, e_ps2 = 0;
  m_t m1, m2;
  p_t p1, p2;
  timed_action_if #(.HEALTH_WIDTH(3), .SCORE_WIDTH(4)) bus1();
  timed_action_if #(.HEALTH_WIDTH(2), .SCORE_WIDTH(2)) bus2();
  assign bus1.ir_in_valid = irv;
  assign bus1.block_in = blk;
  assign bus1.lunge_in = lng;
  assign bus1.tick_in = tick;
  assign bus1.hit_in = hit;
  assign bus1.parry_in = parry;
  assign bus1.opponent_scored_in = opp;
  assign bus2.ir_in_valid = irv;
  assign bus2.block_in = blk;
  assign bus2.lunge_in = lng;
  assign bus2.tick_in = tick;
  assign bus2.hit_in = hit;
  assign bus2.parry_in = parry;
  assign bus2.opponent_scored_in = opp;
  timed_action_fsm dut1 (.clk_pixel_in(clk), .rst_in(rst), .bus(bus1));
  timed_action_fsm #(
    .MAX_HEALTH(2), .HEALTH_WIDTH(2), .SCORE_WIDTH(2), .LUNGE_FRAMES(1),
    .ATTACK_FRAMES(2), .BLOCK_FRAMES(3), .RECOVER_FRAMES(1)
  ) dut2 (.clk_pixel_in(clk), .rst_in(rst), .bus(bus2));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask
  function automatic int dur(input int s, input p_t p);
    return s == S_LUNGE ? p.lf : s == S_ATTACK ? p.af : s == S_BLOCK ? p.bf : s == S_RECOVER ? p.rf : 0;
  endfunction
  function automatic int saber(input int s);
    return s == S_LUNGE ? 1 : s == S_BLOCK ? 2 : s == S_ATTACK ? 3 : 0;
  endfunction
  function automatic m_t mreset(input p_t p);
    m_t m;
    m.st = S_REST; m.left = 0; m.health = p.mh; m.score = 0; m.bq = 0; m.lq = 0;
    return m;
  endfunction
  // model keeps the ticks remaining in the current state; a timed state ends on its last one
  task automatic mstep(inout m_t m, input p_t p, input bit h, input bit pa, input bit o, output bit sc);
    bit dmg = 0, inc = 0, last = (m.left == 1);
    int nx = m.st;
    if (m.st == S_REST) begin
      if (o) dmg = 1; else if (m.bq) nx = S_BLOCK; else if (m.lq) nx = S_LUNGE;
    end else if (m.st == S_BLOCK) begin
      if (pa) begin inc = 1; nx = S_RECOVER; end
      else if (!m.bq) nx = S_REST;
      else if (last) nx = S_RECOVER;
    end else if (m.st == S_LUNGE) begin
      if (o) dmg = 1; else if (last) nx = S_ATTACK;
    end else if (m.st == S_ATTACK) begin
      if (h && o) begin inc = 1; dmg = 1; end
      else if (h) nx = S_SCORE;
      else if (o) dmg = 1;
      else if (!m.lq || last) nx = S_RECOVER;
    end else if (m.st == S_SCORE) begin
      inc = 1; nx = S_RECOVER;
    end else if (m.st == S_RECOVER) begin
      if (last) nx = S_REST;
    end
    if (dmg) begin
      m.health--;
      nx = m.health == 0 ? S_DEAD : S_RECOVER;
    end
    if (inc && m.score < p.smax) m.score++;
    sc = inc;
    if (nx != m.st) begin
      m.st = nx;
      m.left = dur(nx, p);
    end else m.left--;
  endtask
  initial begin
    p1 = '{2, 8, 30, 4, 5, 15};
    p2 = '{1, 2, 3, 1, 2, 3};
    forever begin
      @(posedge clk);
      if (rst) begin
        m1 = mreset(p1); m2 = mreset(p2);
        e_dv = 0; e_ps1 = 0; e_ps2 = 0;
      end else begin
        e_dv = tick; e_ps1 = 0; e_ps2 = 0;
        if (tick) begin
          mstep(m1, p1, hit, parry, opp, e_ps1);
          mstep(m2, p2, hit, parry, opp, e_ps2);
        end
        if (irv) begin
          m1.bq = blk; m1.lq = lng & ~blk;
          m2.bq = blk; m2.lq = lng & ~blk;
        end
      end
      armed = 1;
    end
  end
  initial forever begin
    @(negedge clk);
    if (armed) begin
      chk("d1_saber", bus1.saber_state_out, saber(m1.st));
      chk("d1_health", bus1.health_out, m1.health);
      chk("d1_score", bus1.score_out, m1.score);
      chk("d1_over", bus1.game_over_out, m1.st == S_DEAD);
      chk("d1_valid", bus1.data_out_valid, e_dv);
      chk("d1_scored", bus1.player_scored_out, e_ps1);
      chk("d2_saber", bus2.saber_state_out, saber(m2.st));
      chk("d2_health", bus2.health_out, m2.health);
      chk("d2_score", bus2.score_out, m2.score);
      chk("d2_over", bus2.game_over_out, m2.st == S_DEAD);
      chk("d2_valid", bus2.data_out_valid, e_dv);
      chk("d2_scored", bus2.player_scored_out, e_ps2);
      if (bus1.data_out_valid === 1'b1) pulses1++;
      if (bus2.player_scored_out === 1'b1) ps2++;
    end
  end
  task automatic drive(input bit t, input bit h, input bit p, input bit o, input bit v, input bit b, input bit l);
    @(negedge clk);
    tick = t; hit = h; parry = p; opp = o; irv = v; blk = b; lng = l;
  endtask
  task automatic frame(input bit h, input bit p, input bit o);
    drive(1, h, p, o, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic press(input bit b, input bit l);
    drive(0, 0, 0, 0, 1, b, l);
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic do_reset;
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask
  initial begin
    do_reset;
    pulses1 = 0;
    repeat (3) frame(0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("s1_pulses", pulses1, 3);
    chk("s1_health", bus1.health_out, 5);
    chk("s1_score", bus1.score_out, 0);
    chk("s1_saber", bus1.saber_state_out, 0);
    chk("s1_model_health", m1.health, 5);
    press(0, 1);
    frame(0, 0, 0); chk("s2_lunge_a", bus1.saber_state_out, 1);
    frame(0, 0, 0); chk("s2_lunge_b", bus1.saber_state_out, 1);
    frame(0, 0, 0); chk("s2_attack", bus1.saber_state_out, 3);
    frame(1, 0, 0); chk("s2_score_st", bus1.saber_state_out, 0); chk("s2_score_pre", bus1.score_out, 0);
    frame(0, 0, 0); chk("s2_score", bus1.score_out, 1); chk("s2_pulse", bus1.player_scored_out, 1);
    chk("s2_model_score", m1.score, 1);
    repeat (3) frame(0, 0, 0);
    chk("s2_recover", bus1.saber_state_out, 0);
    frame(0, 0, 0); chk("s2_rest", bus1.saber_state_out, 0);
    frame(0, 0, 0); chk("s2_relunge", bus1.saber_state_out, 1);
    press(0, 0);
    repeat (7) frame(0, 0, 0);
    press(1, 0);
    frame(0, 0, 0); chk("s3_block", bus1.saber_state_out, 2);
    for (int i = 2; i <= 30; i++) frame(0, 0, i == 10);
    chk("s3_block_held", bus1.saber_state_out, 2);
    chk("s3_no_damage", bus1.health_out, 5);
    frame(0, 0, 0); chk("s3_fatigue", bus1.saber_state_out, 0);
    repeat (4) frame(0, 0, 0);
    frame(0, 0, 0); chk("s3_reblock", bus1.saber_state_out, 2);
    repeat (4) frame(0, 0, 0);
    frame(0, 1, 0);
    chk("s3_parry_score", bus1.score_out, 2);
    chk("s3_parry_pulse", bus1.player_scored_out, 1);
    chk("s3_parry_exit", bus1.saber_state_out, 0);
    press(0, 0);
    repeat (4) frame(0, 0, 0);
    press(0, 1);
    repeat (3) frame(0, 0, 0);
    chk("s4_attack", bus1.saber_state_out, 3);
    frame(1, 0, 1);
    chk("s4_score", bus1.score_out, 3);
    chk("s4_health", bus1.health_out, 4);
    chk("s4_saber", bus1.saber_state_out, 0);
    chk("s4_pulse", bus1.player_scored_out, 1);
    press(0, 0);
    repeat (4) frame(0, 0, 0);
    do_reset;
    for (int k = 1; k <= 5; k++) begin
      frame(0, 0, 1);
      chk("s5_health", bus1.health_out, 5 - k);
      chk("s5_over", bus1.game_over_out, k == 5);
      if (k < 5) repeat (4) frame(0, 0, 0);
    end
    press(0, 1);
    repeat (3) frame(1, 0, 0);
    press(1, 0);
    repeat (3) frame(1, 1, 0);
    chk("s5_dead_health", bus1.health_out, 0);
    chk("s5_dead_score", bus1.score_out, 0);
    chk("s5_dead_saber", bus1.saber_state_out, 0);
    chk("s5_dead_over", bus1.game_over_out, 1);
    do_reset;
    press(0, 1);
    repeat (3) frame(0, 0, 0);
    chk("s6_attack", bus1.saber_state_out, 3);
    drive(1, 1, 0, 0, 0, 0, 0);
    rst = 1;
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 0;
    chk("s6_saber", bus1.saber_state_out, 0);
    chk("s6_health", bus1.health_out, 5);
    chk("s6_score", bus1.score_out, 0);
    chk("s6_valid", bus1.data_out_valid, 0);
    chk("s6_pulse", bus1.player_scored_out, 0);
    chk("s6_over", bus1.game_over_out, 0);
    frame(0, 0, 0); chk("s6_latch_cleared", bus1.saber_state_out, 0);
    do_reset;
    press(0, 1);
    for (int pt = 1; pt <= 4; pt++) begin
      frame(0, 0, 0);
      frame(0, 0, 0);
      frame(1, 0, 0);
      frame(0, 0, 0);
      chk("s7_sat_score", bus2.score_out, pt < 3 ? pt : 3);
      chk("s7_sat_pulse", bus2.player_scored_out, 1);
      frame(0, 0, 0);
    end
    press(0, 0);
    repeat (4000) begin
      @(negedge clk);
      rst = $urandom_range(299) == 0;
      tick = $urandom_range(2) == 0;
      hit = $urandom_range(3) == 0;
      parry = $urandom_range(4) == 0;
      opp = $urandom_range(7) == 0;
      irv = $urandom_range(5) == 0;
      blk = 1'($urandom_range(1));
      lng = 1'($urandom_range(1));
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 0;
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/timed_action_fsm.md
# timed_action_fsm

Per-player fencing action controller with frame-based timing, parametrised health/score widths and durations. Consumes latched IR button state plus per-frame collision results (own hit, parry, opponent score) and produces the player's saber state, health, score and a per-frame output strobe for the syncer/packet path. It adds real lunge wind-up, attack timeout, block fatigue, recovery invulnerability, double-touch handling and a terminal game-over state.

## Interface

Parameters:
- MAX_HEALTH, 5: health loaded at reset; ≥1.
- HEALTH_WIDTH, 3: width of health_out; must hold MAX_HEALTH.
- SCORE_WIDTH, 4: width of score_out; score saturates at 2^SCORE_WIDTH−1.
- LUNGE_FRAMES, 2: ticks spent in LUNGE before ATTACK; ≥1.
- ATTACK_FRAMES, 8: maximum ticks in ATTACK; ≥1.
- BLOCK_FRAMES, 30: maximum ticks in BLOCK before fatigue; ≥1.
- RECOVER_FRAMES, 4: ticks in RECOVER; ≥1.

Ports (one clock; reset synchronous, active-high):
- clk_pixel_in  in  1  pixel clock.
- rst_in  in  1  synchronous active-high reset.
- ir_in_valid  in  1  block_in/lunge_in valid this cycle.
- block_in  in  1  block button.
- lunge_in  in  1  lunge button.
- tick_in  in  1  one-cycle pulse per frame; all state evaluation happens on tick cycles only.
- hit_in  in  1  own attack intersects opponent (valid on tick).
- parry_in  in  1  opponent attack collided with our block (valid on tick).
- opponent_scored_in  in  1  opponent landed a touch (valid on tick).
- saber_state_out  out  2  00 rest, 01 lunge, 10 block, 11 attack.
- health_out  out  HEALTH_WIDTH  current health.
- score_out  out  SCORE_WIDTH  current score.
- player_scored_out  out  1  one-cycle pulse, coincident with data_out_valid, when score incremented.
- game_over_out  out  1  high while in DEAD.
- data_out_valid  out  1  one-cycle strobe the cycle after each tick.

## Operation

- Button latch: on ir_in_valid, block_q←block_in, lunge_q←lunge_in. If both set, treat as block only (lunge_q←0).
- Frame timer: counts ticks in the current state; cleared on every state change; width clog2 of largest frame parameter + 1.
- Damage: opponent_scored_in in REST, LUNGE or ATTACK → health−1 and go RECOVER; if the resulting health is 0, go DEAD instead. Ignored in BLOCK, SCORE, RECOVER and DEAD.
- Score increment: score+1 unless already at max (no wrap); pulses player_scored_out even when saturated.
- States and transitions (evaluated on tick_in only; listed in priority order):
  - REST (00): damage → RECOVER/DEAD; block_q → BLOCK; lunge_q → LUNGE.
  - BLOCK (10): parry_in → score+1 and RECOVER; !block_q → REST; timer = BLOCK_FRAMES−1 → RECOVER.
  - LUNGE (01): damage; timer = LUNGE_FRAMES−1 → ATTACK. Releasing lunge here does not abort.
  - ATTACK (11): hit_in and opponent_scored_in together (double touch) → score+1 and damage, go RECOVER/DEAD; hit_in → SCORE; damage; !lunge_q or timer = ATTACK_FRAMES−1 → RECOVER.
  - SCORE (00): score+1 → RECOVER.
  - RECOVER (00): timer = RECOVER_FRAMES−1 → REST.
  - DEAD (00): absorbing until rst_in.
- Reset: state REST, timer 0, block_q=lunge_q=0, health_out=MAX_HEALTH, score_out=0, saber_state_out=00, player_scored_out=0, game_over_out=0, data_out_valid=0. Reset mid-frame discards any pending tick.

## Timing

- The tick on cycle N is evaluated with hit_in/parry_in/opponent_scored_in sampled on cycle N and with block_q/lunge_q as registered before N. An ir_in_valid on cycle N takes effect at the next tick.
- All outputs are registered and update at cycle N+1. data_out_valid is high for exactly cycle N+1, and player_scored_out is high only on that same cycle.
- Back-to-back ticks (cycles N and N+1) are legal. Each produces its own strobe.
- With no tick_in, state, timer and outputs hold; data_out_valid stays 0.
- Durations: the state lasts exactly X_FRAMES ticks (timer 0..X_FRAMES−1). With X_FRAMES=1, the exit occurs on the first tick in that state.

## Test plan

- Reset, then 3 ticks with no input → health_out=5, score_out=0, saber_state_out=00, data_out_valid pulses 3 times, each one cycle after its tick.
- Lunge press, LUNGE_FRAMES=2 → saber_state 01 for 2 ticks, then 11; hit_in on the 1st ATTACK tick → SCORE on the next strobe; score_out=1 with player_scored_out pulse; then RECOVER for 4 ticks, then REST.
- Block held for 30 ticks with no parry → BLOCK fatigue exit to RECOVER after the 30th tick. Repeat with parry_in on tick 5 → score+1 and RECOVER. opponent_scored_in during BLOCK leaves health_out=5.
- In ATTACK, assert hit_in and opponent_scored_in on the same tick → score_out+1, health_out=4, next state RECOVER, single player_scored_out pulse.
- 5 opponent touches while in REST, each followed by recovery → health 4,3,2,1,0; game_over_out=1 on the 5th strobe; further lunge, block and hit_in inputs leave health, score and state unchanged.
- With SCORE_WIDTH=2, score 3 times then score again → score_out stays 3 and player_scored_out still pulses. Assert rst_in mid-ATTACK → next cycle all outputs are at their reset values.
